// File: rtl/bch_pkg.sv
// Shared constants and types for the (14,8) BCH encoder/decoder pair.
// Generator g(x) = x^5 + x^2 + 1, single-error-correcting.
package bch_pkg;

    localparam int BCH_N = 14;
    localparam int BCH_K = 8;
    localparam int BCH_SYN_W = 5;
    localparam logic [BCH_SYN_W:0] BCH_G_POLY = 6'b100101;

    typedef logic [BCH_N-1:0] codeword_t;
    typedef logic [BCH_K-1:0] message_t;
    typedef logic [BCH_SYN_W-1:0] syndrome_t;

    typedef enum logic [2:0] {
        IDLE,
        DIV1,
        SEARCH,
        DIV2,
        DONE
    } dec_state_t;

endpackage

// File: rtl/bch_poly_div_serial.sv
// Serial GF(2) polynomial divider, MSB first, one bit per enabled cycle.
// Quotient is truncated to its low K bits; done pulses after the last bit.
module bch_poly_div_serial
    import bch_pkg::*;
#(
    parameter int N = BCH_N,
    parameter int K = BCH_K,
    parameter int SYN_W = BCH_SYN_W,
    parameter logic [SYN_W:0] G_POLY = BCH_G_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [N-1:0]     word,
    output logic [SYN_W-1:0] rem,
    output logic [K-1:0]     quot,
    output logic [K-1:0]     quot_nxt,
    output logic             last,
    output logic             done
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]    cnt;
    logic             din;
    logic             top_bit;
    logic             run;
    logic [SYN_W-1:0] rem_nxt;

    // Pick the word bit for the current step, highest power first
    always_comb begin
        din = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(N - 1 - i)) begin
                din = word[i];
            end
        end
    end

    // One long-division step: shift in next bit, subtract g when the leading term overflows
    always_comb begin
        top_bit  = rem[SYN_W-1];
        rem_nxt  = {rem[SYN_W-2:0], din} ^ (top_bit ? G_POLY[SYN_W-1:0] : '0);
        quot_nxt = {quot[K-2:0], top_bit};
        run      = en && (cnt != CW'(N));
        last     = en && (cnt == CW'(N - 1));
    end

    // Shift registers and bit counter; clr restarts a division
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            quot <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            rem  <= '0;
            quot <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (run) begin
                rem  <= rem_nxt;
                quot <= quot_nxt;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bch_serial_decoder.sv
// Single-error-correcting BCH decoder: divide, LFSR error search, re-divide.
// Results are held in DONE until the consumer accepts them.
module bch_serial_decoder
    import bch_pkg::*;
#(
    parameter int N = BCH_N,
    parameter int K = BCH_K,
    parameter int SYN_W = BCH_SYN_W,
    parameter logic [SYN_W:0] G_POLY = BCH_G_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_data,
    output logic [SYN_W-1:0] out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorrectable
);

    localparam int PW = $clog2(N);

    dec_state_t state_q;
    dec_state_t state_d;

    logic [N-1:0]     word_q;
    logic [SYN_W-1:0] syn_q;
    logic [SYN_W-1:0] s_q;
    logic [PW-1:0]    p_q;
    logic [K-1:0]     data_q;
    logic [SYN_W-1:0] syn_out_q;
    logic             corr_q;
    logic             unc_q;

    logic [SYN_W-1:0] div_rem;
    logic [K-1:0]     div_quot;
    logic [K-1:0]     div_quot_nxt;
    logic             div_last;
    logic             div_done;
    logic             div_en;
    logic             div_clr;

    logic             match;
    logic             p_last;
    logic             accept;
    logic             hit;
    logic             syn_load;
    logic             ld_clean;
    logic             ld_unc;
    logic             ld_fix;
    logic [N-1:0]     flip_mask;
    logic [SYN_W-1:0] s_nxt;

    bch_poly_div_serial #(
        .N      (N),
        .K      (K),
        .SYN_W  (SYN_W),
        .G_POLY (G_POLY)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .clr      (div_clr),
        .en       (div_en),
        .word     (word_q),
        .rem      (div_rem),
        .quot     (div_quot),
        .quot_nxt (div_quot_nxt),
        .last     (div_last),
        .done     (div_done)
    );

    // Search helpers: s_q tracks x^p mod g alongside position p
    always_comb begin
        match     = (s_q == syn_q);
        p_last    = (p_q == PW'(N - 1));
        s_nxt     = {s_q[SYN_W-2:0], 1'b0} ^ (s_q[SYN_W-1] ? G_POLY[SYN_W-1:0] : '0);
        flip_mask = {{(N-1){1'b0}}, 1'b1} << p_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) state_d = DIV1;
            end
            DIV1: begin
                if (div_done) state_d = (div_rem == '0) ? DONE : SEARCH;
            end
            SEARCH: begin
                if (match) state_d = DIV2;
                else if (p_last) state_d = DONE;
            end
            DIV2: begin
                if (div_last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        accept    = in_ready && in_valid;
        div_en    = (state_q == DIV1) || (state_q == DIV2);
        hit       = (state_q == SEARCH) && match;
        div_clr   = accept || hit;
        syn_load  = (state_q == DIV1) && div_done;
        ld_clean  = syn_load && (div_rem == '0);
        ld_unc    = (state_q == SEARCH) && !match && p_last;
        ld_fix    = (state_q == DIV2) && div_last;
    end

    // Working word, syndrome and LFSR search registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            syn_q  <= '0;
            s_q    <= '0;
            p_q    <= '0;
        end else begin
            if (accept) begin
                word_q <= in_word;
            end else if (hit) begin
                word_q <= word_q ^ flip_mask;
            end
            if (syn_load) begin
                syn_q <= div_rem;
                s_q   <= {{(SYN_W-1){1'b0}}, 1'b1};
                p_q   <= '0;
            end else if ((state_q == SEARCH) && !match) begin
                s_q <= s_nxt;
                p_q <= p_q + 1'b1;
            end
        end
    end

    // Result registers, written only on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            syn_out_q <= '0;
            corr_q    <= 1'b0;
            unc_q     <= 1'b0;
        end else if (ld_clean) begin
            data_q    <= div_quot;
            syn_out_q <= div_rem;
            corr_q    <= 1'b0;
            unc_q     <= 1'b0;
        end else if (ld_unc) begin
            data_q    <= div_quot;
            syn_out_q <= syn_q;
            corr_q    <= 1'b0;
            unc_q     <= 1'b1;
        end else if (ld_fix) begin
            data_q    <= div_quot_nxt;
            syn_out_q <= syn_q;
            corr_q    <= 1'b1;
            unc_q     <= 1'b0;
        end
    end

    assign out_data          = data_q;
    assign out_syndrome      = syn_out_q;
    assign out_corrected     = corr_q;
    assign out_uncorrectable = unc_q;

endmodule

// File: tb/tb_bch_serial_decoder.sv
// Bench for bch_serial_decoder: directed cases plus random words
// checked against a long-division GF(2) reference model.
module tb_bch_serial_decoder;

    localparam int N = 14;
    localparam int K = 8;
    localparam logic [5:0] G = 6'b100101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [4:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorrectable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bch_serial_decoder dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_word           (in_word),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_syndrome      (out_syndrome),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // c(x) = m(x) * g(x)
    function automatic logic [13:0] encode(input logic [7:0] m);
        logic [13:0] c = '0;
        for (int i = 0; i < K; i++)
            if (m[i]) c = c ^ (14'(G) << i);
        return c;
    endfunction

    function automatic logic [4:0] poly_mod(input logic [13:0] w);
        logic [13:0] r = w;
        for (int i = N - 1; i >= 5; i--)
            if (r[i]) r = r ^ (14'(G) << (i - 5));
        return r[4:0];
    endfunction

    function automatic logic [7:0] poly_div(input logic [13:0] w);
        logic [13:0] r = w;
        logic [8:0]  q = '0;
        for (int i = N - 1; i >= 5; i--)
            if (r[i]) begin
                r = r ^ (14'(G) << (i - 5));
                q[i-5] = 1'b1;
            end
        return q[7:0];
    endfunction

    task automatic run_word(input logic [13:0] w, input string tag);
        logic [4:0] syn;
        int         pos;
        int         exp_lat;
        logic [7:0] exp_data;
        logic       exp_corr;
        logic       exp_unc;
        int         lat;
        syn = poly_mod(w);
        pos = -1;
        for (int p = 0; p < N; p++)
            if (pos < 0 && poly_mod(14'(1) << p) == syn) pos = p;
        if (syn == 0) begin
            exp_lat = N + 1; exp_data = poly_div(w); exp_corr = 0; exp_unc = 0;
        end else if (pos >= 0) begin
            exp_lat = 2 * N + pos + 2;
            exp_data = poly_div(w ^ (14'(1) << pos));
            exp_corr = 1; exp_unc = 0;
        end else begin
            exp_lat = 2 * N + 1; exp_data = poly_div(w); exp_corr = 0; exp_unc = 1;
        end
        check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = 14'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/data"}, 32'(out_data), 32'(exp_data));
        check({tag, "/syndrome"}, 32'(out_syndrome), 32'(syn));
        check({tag, "/corrected"}, 32'(out_corrected), 32'(exp_corr));
        check({tag, "/uncorrectable"}, 32'(out_uncorrectable), 32'(exp_unc));
        if (exp_corr) check({tag, "/div2_rem"}, 32'(dut.u_div.rem), 32'd0);
        @(posedge clk); #1;
        check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [13:0] w;
        logic [7:0]  m;
        int          a;
        int          b;
        int          kind;
        int          lat;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/data", 32'(out_data), 32'd0);
        check("reset/syndrome", 32'(out_syndrome), 32'd0);
        check("reset/corrected", 32'(out_corrected), 32'd0);
        check("reset/uncorrectable", 32'(out_uncorrectable), 32'd0);

        run_word(14'h1742, "clean_aa");
        run_word(14'h174A, "err_bit3");
        run_word(14'h0742, "err_bit12");
        run_word(14'h1741, "double_0_1");

        for (int p = 0; p < N; p++)
            run_word(encode(8'hAA) ^ (14'(1) << p), $sformatf("aa_bit%0d", p));

        for (int n = 0; n < 300; n++) begin
            m    = 8'($urandom);
            kind = int'($urandom_range(0, 2));
            w    = encode(m);
            a    = int'($urandom_range(0, N - 1));
            b    = (a + 1 + int'($urandom_range(0, N - 2))) % N;
            if (kind >= 1) w = w ^ (14'(1) << a);
            if (kind == 2) w = w ^ (14'(1) << b);
            run_word(w, $sformatf("rand%0d", n));
        end

        // Backpressure: result must hold and a second word must be ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = encode(8'h3C);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp/latency", 32'(lat), 32'(N + 1));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_word  = encode(8'hC3);
            @(posedge clk); #1;
            check("bp/held_valid", 32'(out_valid), 32'd1);
            check("bp/in_ready_low", 32'(in_ready), 32'd0);
            check("bp/held_data", 32'(out_data), 32'h3C);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp/release_valid", 32'(out_valid), 32'd0);
        run_word(encode(8'h5A), "bp_next");

        // Reset while searching for an error at the last position
        in_valid = 1'b1;
        in_word  = encode(8'h77) ^ (14'(1) << 13);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (N + 6) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("midrst/in_ready", 32'(in_ready), 32'd1);
        check("midrst/out_valid", 32'(out_valid), 32'd0);
        check("midrst/data", 32'(out_data), 32'd0);
        check("midrst/syndrome", 32'(out_syndrome), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_word(encode(8'h81), "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_serial_decoder.md
Name: bch_serial_decoder

Overview:
- Single-error-correcting decoder for the BCH/cyclic channel: inverse of the encoder, which produces c(x) = m(x)·g(x) over GF(2), with an 8-bit message and g = 6'b100101 (x^5+x^2+1).
- Takes a 14-bit received word after noise/error injection.
- Computes the syndrome by serial polynomial division and locates a single error with an LFSR search.
- Re-divides the corrected word to recover the message.
- Sits between the error-generation stage and the result/UART reporting path.

Parameters:
N, 14, received word width (bit positions 0..N-1; N must be ≤ 31, the period of g)
K, 8, message width (low K bits of the quotient)
G_POLY, 6'b100101, generator polynomial, MSB = x^5
SYN_W, 5, syndrome width = deg(g)

Ports:
clk  in  1  system clock
rst  in  1  reset
in_valid  in  1  received word valid
in_ready  out  1  decoder idle, word accepted on in_valid&&in_ready
in_word  in  N  received polynomial, bit i = coeff of x^i
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts on out_valid&&out_ready
out_data  out  K  decoded message
out_syndrome  out  SYN_W  syndrome of the received (uncorrected) word
out_corrected  out  1  exactly one bit was flipped
out_uncorrectable  out  1  nonzero syndrome matched no position

Interface:
- One clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out_data, out_syndrome=0; out_corrected=0, out_uncorrectable=0; internal registers=0.
- States: IDLE, DIV1, SEARCH, DIV2, DONE.
- IDLE: in_ready=1. On handshake, capture in_word into word_q, clear rem/quot/bit counter, go to DIV1.
- DIV1: N cycles, MSB first (bit N-1 first).
  - Per cycle: t = rem[4]; rem <= {rem[3:0], bit} ^ (t ? G_POLY[4:0] : 0); quot <= {quot, t}.
  - After N cycles, rem = word mod g, stored as syndrome.
  - Syndrome = 0: go to DONE with out_data = quot[K-1:0], corrected=0.
  - Otherwise: go to SEARCH.
- SEARCH: s starts at 5'b00001 (x^0 mod g), position p starts at 0.
  - Each cycle compare s against the syndrome.
  - Match: flip word_q[p], go to DIV2.
  - No match: s <= {s[3:0],0} ^ (s[4] ? G_POLY[4:0] : 0); p++.
  - p = N-1 with no match: go to DONE with uncorrectable=1 and out_data = DIV1 quot[K-1:0].
- DIV2: same division on the corrected word, N cycles. Then DONE with out_data = quot[K-1:0] and corrected=1. The DIV2 remainder must be 0; the bench asserts this.
- The quotient has N-5 significant bits; bits above K-1 are dropped.
- DONE: out_valid=1, outputs stable until out_ready. On handshake go to IDLE, out_valid=0 next cycle.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored and not captured.
- Latency, measured from the accept edge to the first cycle out_valid=1:
  - Clean word: N+1.
  - Error at position p: N+1+(p+1)+N.
  - Uncorrectable: 2N+1.
- out_valid with out_ready already high: accepted in the first DONE cycle. A new word may be accepted the following cycle.
- Reset asserted mid-operation: immediately returns to IDLE with reset values. No partial result is emitted.
- out_syndrome, out_corrected and out_uncorrectable are valid only while out_valid=1. They may change only on entry to DONE.

Decomposition:
- Shared package bch_pkg: BCH_N, BCH_K, BCH_SYN_W, BCH_G_POLY constants; dec_state_t enum (IDLE, DIV1, SEARCH, DIV2, DONE); codeword/message/syndrome typedefs. The encoder uses the same package.
- One natural sub-module: bch_poly_div_serial. It holds the rem/quot shift registers, the bit counter and a done pulse, and is reused for DIV1 and DIV2. The LFSR search stays in the top.

Test Plan:
- Clean: in_word=14'h1742 (m=8'hAA) -> out_valid after 15 cycles; out_data=8'hAA, syndrome=0, corrected=0, uncorrectable=0.
- Single error bit 3: 14'h174A -> syndrome=5'h08, corrected=1, out_data=8'hAA, latency 15+4+14=33.
- Single error bit 12: 14'h0742 -> syndrome=5'h0E (x^12 mod g), corrected=1, out_data=8'hAA. Repeat for every bit 0..13 of every 8-bit message against a GF(2) reference model.
- Double error bits 0,1: 14'h1741 -> syndrome=5'h03, uncorrectable=1, corrected=0, latency 29.
- Backpressure: hold out_ready=0 for 20 cycles -> outputs stable, in_ready=0, a second in_valid is not captured. Release -> next word accepted the cycle after the handshake.
- Reset during SEARCH -> in_ready=1 and out_valid=0 after reset. A subsequent clean word decodes correctly.
